// File: rtl/bayer_mosaic_tx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | bayer_mosaic_tx                                                         |
// | RGB444 raster to RGGB Bayer samples with address, via an FWFT FIFO.     |
// | Option macro: BAYER_ZERO_FILL_EN (zero the two unselected channels).    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module bayer_mosaic_tx #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 7,
   parameter int FRAME_W    = 10,
   parameter int FRAME_H    = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_pix,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int XW    = $clog2(FRAME_W + 1);
   localparam int YW    = $clog2(FRAME_H + 1);
   localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic [ADDR_WIDTH-1:0] addr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [ENT_W-1:0]      mem [FIFO_DEPTH];

   logic                  push;
   logic                  pop;
   logic                  last_x;
   logic                  last_y;
   logic [DATA_WIDTH-1:0] mosaic;
   logic [ENT_W-1:0]      head;

   assign in_ready   = (state == S_RUN) && (count < CNT_W'(FIFO_DEPTH));
   assign out_valid  = (count != '0);
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign last_x     = (x == XW'(FRAME_W - 1));
   assign last_y     = (y == YW'(FRAME_H - 1));
   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_DONE);

`ifdef BAYER_ZERO_FILL_EN
   localparam int CH = DATA_WIDTH / 3;
   logic [DATA_WIDTH-1:0] mask;

   // RGGB: even/even is R (top field), odd/odd is B (bottom field), rest G.
   always_comb begin
      mask = '0;
      if (!x[0] && !y[0])
         mask[2*CH +: CH] = '1;
      else if (x[0] && y[0])
         mask[0 +: CH] = '1;
      else
         mask[CH +: CH] = '1;
   end
   assign mosaic = in_pix & mask;
`else
   assign mosaic = in_pix;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         x      <= '0;
         y      <= '0;
         addr   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state  <= S_RUN;
                  x      <= '0;
                  y      <= '0;
                  addr   <= '0;
                  wr_ptr <= '0;
                  rd_ptr <= '0;
                  count  <= '0;
               end
            end
            S_RUN:   if (push && last_x && last_y) state <= S_DRAIN;
            S_DRAIN: if (count == '0) state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         // in_ready is low in IDLE, so these never collide with the start clear
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            addr   <= addr + ADDR_WIDTH'(1);
            if (last_x) begin
               x <= '0;
               y <= y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (!push && pop)
            count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {addr, mosaic};
   end

   assign head     = mem[rd_ptr];
   assign out_addr = out_valid ? head[ENT_W-1:DATA_WIDTH] : '0;
   assign out_data = out_valid ? head[DATA_WIDTH-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_bayer_mosaic_tx.sv
`default_nettype none
// Bench for bayer_mosaic_tx: directed frames checked by a scoreboard model.
module tb_bayer_mosaic_tx;

   localparam int W = 10;
   localparam int H = 10;
`ifdef BAYER_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [11:0] in_pix = '0;
   logic        in_ready;
   logic        out_valid;
   logic [11:0] out_data;
   logic [6:0]  out_addr;
   logic        busy;
   logic        frame_done;

   bayer_mosaic_tx #(
      .DATA_WIDTH(12), .ADDR_WIDTH(7), .FRAME_W(W), .FRAME_H(H), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [18:0] q[$];
   int          m_phase = 0;
   int          m_x = 0;
   int          m_y = 0;
   int          acc_cnt = 0;
   int          pop_cnt = 0;
   int          pop_base = 0;
   int          fd_cnt = 0;
   logic [11:0] cap [0:127];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] exp_data(input logic [11:0] p, input int x, input int y);
      logic [11:0] m;
      if (x % 2 == 0 && y % 2 == 0)      m = 12'hF00;
      else if (x % 2 == 1 && y % 2 == 1) m = 12'h00F;
      else                               m = 12'h0F0;
      return ZF ? (p & m) : p;
   endfunction

   // Scoreboard and handshake model, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, (m_phase == 1 && q.size() < 4)});
         chk("busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
         chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
         if (out_valid && q.size() != 0) begin
            chk("out_addr", {25'd0, out_addr}, {25'd0, q[0][18:12]});
            chk("out_data", {20'd0, out_data}, {20'd0, q[0][11:0]});
            if (out_ready) begin
               cap[out_addr] = out_data;
               void'(q.pop_front());
               pop_cnt++;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back({7'(m_y * W + m_x), exp_data(in_pix, m_x, m_y)});
            acc_cnt++;
            if (m_x == W - 1 && m_y == H - 1) m_phase = 2;
            if (m_x == W - 1) begin
               m_x = 0;
               m_y++;
            end else begin
               m_x++;
            end
         end
         if (start && m_phase == 0) begin
            m_phase = 1;
            m_x = 0;
            m_y = 0;
         end
         if (frame_done) begin
            chk("fd_phase", m_phase, 2);
            chk("fd_empty", q.size(), 0);
            fd_cnt++;
            m_phase = 0;
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      pop_base = pop_cnt;
      cycle();
      start = 1'b0;
   endtask

   task automatic run_frame(input int pv, input int pr, input logic [11:0] pix,
                            input bit fixed, input bit poke);
      int fd0 = fd_cnt;
      bit poked_run = 1'b0;
      bit poked_drain = 1'b0;
      for (int i = 0; i < 3000 && fd_cnt == fd0; i++) begin
         in_valid  = ($urandom_range(0, 99) < pv);
         out_ready = ($urandom_range(0, 99) < pr);
         in_pix    = fixed ? pix : 12'($urandom);
         start     = 1'b0;
         if (poke && !poked_run && i == 30 && m_phase == 1) begin
            start = 1'b1;
            poked_run = 1'b1;
         end
         if (poke && !poked_drain && m_phase == 2) begin
            start = 1'b1;
            poked_drain = 1'b1;
         end
         cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      start = 1'b0;
      chk("frame_done_seen", fd_cnt, fd0 + 1);
      chk("frame_pops", pop_cnt - pop_base, 100);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      repeat (3) cycle();
      chk("frame_done_once", fd_cnt, fd0 + 1);
   endtask

   initial begin
      int base;
      #2;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {20'd0, out_data}, 32'd0);
      chk("rst_out_addr", {25'd0, out_addr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cycle();

      // Constant pixel, always-ready sink.
      pulse_start();
      run_frame(100, 100, 12'hABC, 1'b1, 1'b0);
      chk("addr0_R", {20'd0, cap[0]}, ZF ? 32'hA00 : 32'hABC);
      chk("addr1_G", {20'd0, cap[1]}, ZF ? 32'h0B0 : 32'hABC);
      chk("addr11_B", {20'd0, cap[11]}, ZF ? 32'h00C : 32'hABC);

      // Stalled sink: FIFO fills to 4 and head holds.
      pulse_start();
      base = acc_cnt;
      in_valid = 1'b1;
      out_ready = 1'b0;
      repeat (8) begin
         in_pix = 12'($urandom);
         cycle();
      end
      chk("stall_accepts", acc_cnt - base, 4);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out_addr", {25'd0, out_addr}, 32'd0);
      run_frame(100, 100, 12'h000, 1'b0, 1'b0);

      // Random handshakes on both sides.
      pulse_start();
      run_frame(50, 50, 12'h000, 1'b0, 1'b0);

      // Mid-frame reset after 37 pixels.
      pulse_start();
      base = acc_cnt;
      for (int i = 0; i < 500; i++) begin
         if (acc_cnt - base >= 37) break;
         in_valid  = 1'b1;
         out_ready = ($urandom_range(0, 99) < 30);
         in_pix    = 12'($urandom);
         cycle();
      end
      chk("rst_mid_accepts", acc_cnt - base, 37);
      rst = 1'b1;
      q.delete();
      m_phase = 0;
      #1;
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      out_ready = 1'b0;
      cycle();
      rst = 1'b0;
      cycle();
      pulse_start();
      run_frame(90, 70, 12'h000, 1'b0, 1'b0);

      // start pulses during RUN and DRAIN must be ignored.
      pulse_start();
      run_frame(80, 60, 12'h000, 1'b0, 1'b1);

      // Channel field of the first sample.
      pulse_start();
      run_frame(100, 100, 12'h5A3, 1'b1, 1'b0);
      chk("addr0_5A3", {20'd0, cap[0]}, ZF ? 32'h500 : 32'h5A3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
